// File: rtl/peri_seq_ctrl_pkg.sv
// Shared types and defaults for the array peripheral sequencer.
package peri_pkg;

    localparam int unsigned COL_NO_DEF      = 128;
    localparam int unsigned PAIR_ROW_NO_DEF = 64;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_SET   = 2'd1,
        OP_RESET = 2'd2
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        DONE
    } state_e;

    // A zero length field encodes a full sweep of all columns.
    function automatic int unsigned len_decode(input int unsigned len, input int unsigned col_no);
        return (len == 0) ? col_no : len;
    endfunction

endpackage

// File: rtl/peri_seq_ctrl_phase_cnt.sv
// Loadable down-counter timing the SETUP/PULSE/HOLD phases; last flags zero.
module peri_phase_cnt #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign last = (cnt == '0);

endmodule

// File: rtl/peri_seq_ctrl.sv
// Burst sequencer: sweeps consecutive columns on one pair row with timed en pulses.
module peri_seq_ctrl
    import peri_pkg::*;
#(
    parameter int unsigned COL_NO      = COL_NO_DEF,
    parameter int unsigned PAIR_ROW_NO = PAIR_ROW_NO_DEF,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned PULSE_CYC   = 4,
    parameter int unsigned HOLD_CYC    = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [1:0]                     req_op,
    input  logic [$clog2(COL_NO)-1:0]      req_col,
    input  logic [$clog2(PAIR_ROW_NO)-1:0] req_row,
    input  logic [$clog2(COL_NO)-1:0]      req_len,
    input  logic                           abort,
    output logic                           en,
    output logic [$clog2(COL_NO)-1:0]      col_sel,
    output logic [$clog2(PAIR_ROW_NO)-1:0] row_sel,
    output logic [1:0]                     op,
    output logic                           busy,
    output logic                           done,
    output logic                           aborted
);

    localparam int unsigned CW   = $clog2(COL_NO);
    localparam int unsigned NW   = CW + 1;
    localparam int unsigned MAXC = (SETUP_CYC > PULSE_CYC)
                                   ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                   : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int unsigned PW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [PW-1:0] SETUP_LD = PW'(SETUP_CYC - 1);
    localparam logic [PW-1:0] PULSE_LD = PW'(PULSE_CYC - 1);
    localparam logic [PW-1:0] HOLD_LD  = PW'(HOLD_CYC - 1);

    state_e          state;
    state_e          state_nx;
    logic [NW-1:0]   remaining;
    logic            abort_pend;
    logic            pend_set;
    logic            step_col;
    logic            accept;
    logic            cnt_load;
    logic [PW-1:0]   cnt_val;
    logic            cnt_last;

    assign accept = req_valid && req_ready && ((state == IDLE) || (state == DONE));

    peri_phase_cnt #(
        .W (PW)
    ) u_phase_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .last     (cnt_last)
    );

    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_val  = '0;
        step_col = 1'b0;
        pend_set = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (accept) begin
                    state_nx = SETUP;
                    cnt_load = 1'b1;
                    cnt_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (abort) begin
                    state_nx = DONE;
                end else if (cnt_last) begin
                    state_nx = PULSE;
                    cnt_load = 1'b1;
                    cnt_val  = PULSE_LD;
                end
            end
            PULSE: begin
                // An abort cuts the pulse short but still honours the full hold.
                pend_set = abort;
                if (abort || cnt_last) begin
                    state_nx = HOLD;
                    cnt_load = 1'b1;
                    cnt_val  = HOLD_LD;
                end
            end
            HOLD: begin
                pend_set = abort;
                if (cnt_last) begin
                    if (abort || abort_pend || (remaining <= NW'(1))) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SETUP;
                        cnt_load = 1'b1;
                        cnt_val  = SETUP_LD;
                        step_col = 1'b1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            en         <= 1'b0;
            col_sel    <= '0;
            row_sel    <= '0;
            op         <= OP_READ;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            req_ready  <= 1'b0;
            remaining  <= '0;
            abort_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            en        <= (state_nx == PULSE);
            busy      <= (state_nx == SETUP) || (state_nx == PULSE) || (state_nx == HOLD);
            done      <= (state_nx == DONE);
            aborted   <= (state_nx == DONE) && (abort || abort_pend);
            req_ready <= (state_nx == IDLE) || (state_nx == DONE);
            if (accept) begin
                col_sel    <= req_col;
                row_sel    <= req_row;
                op         <= (req_op == 2'd3) ? OP_READ : req_op;
                remaining  <= NW'(len_decode(32'(req_len), COL_NO));
                abort_pend <= 1'b0;
            end else begin
                abort_pend <= abort_pend | pend_set;
                if (step_col) begin
                    col_sel   <= col_sel + 1'b1;
                    remaining <= remaining - 1'b1;
                end
            end
        end
    end

endmodule
